// File: rtl/uart_mem_loader.sv
// UART 8N1 program loader: parses 'W' addr(16) count(16) data(16 x count) and drives the sram write port.
// Optional trailing checksum byte is enabled by defining LOADER_CKSUM_EN.
module uart_mem_loader #(
   parameter int CLKDIV  = 868,
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_rx,
   output logic [15:0] mem_waddr_o,
   output logic [15:0] mem_wdata_o,
   output logic        mem_wr_o,
   output logic        cpu_hold_o,
   output logic        done_o,
   output logic        err_o
);

   localparam logic [15:0] DIV_LAST  = 16'(CLKDIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKDIV / 2 - 1);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [3:0] {
      P_IDLE, P_ADDR_H, P_ADDR_L, P_CNT_H, P_CNT_L, P_DATA_H, P_DATA_L,
`ifdef LOADER_CKSUM_EN
      P_CKSUM,
`endif
      P_FINISH
   } p_state_t;

`ifdef LOADER_CKSUM_EN
   localparam p_state_t P_AFTER_LAST = P_CKSUM;
`else
   localparam p_state_t P_AFTER_LAST = P_FINISH;
`endif

   rx_state_t   r_rx_state;
   p_state_t    r_p_state;
   logic        r_rx_s1, r_rx_s2, r_rx_prev;
   logic [15:0] r_bit_cnt;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic [7:0]  r_rx_byte;
   logic        r_byte_vld;
   logic        r_frame_err;
   logic [15:0] r_addr, r_cnt, r_waddr, r_wdata;
   logic [7:0]  r_hi;
   logic        r_wr, r_hold, r_done, r_err;
   logic [31:0] r_to_cnt;
`ifdef LOADER_CKSUM_EN
   logic [7:0]  r_sum;
`endif
   logic        w_timeout;

   assign mem_waddr_o = r_waddr;
   assign mem_wdata_o = r_wdata;
   assign mem_wr_o    = r_wr;
   assign cpu_hold_o  = r_hold;
   assign done_o      = r_done;
   assign err_o       = r_err;

   // Receiver: start bit re-checked mid-bit, then every sample lands mid-bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_s1     <= 1'b1;
         r_rx_s2     <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_rx_state  <= RX_IDLE;
         r_bit_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_rx_byte   <= '0;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_s1     <= uart_rx;
         r_rx_s2     <= r_rx_s1;
         r_rx_prev   <= r_rx_s2;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               r_bit_cnt <= '0;
               if (r_rx_prev && !r_rx_s2) r_rx_state <= RX_START;
            end
            RX_START: begin
               if (r_bit_cnt == HALF_LAST) begin
                  r_bit_cnt  <= '0;
                  r_bit_idx  <= '0;
                  r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
               end else r_bit_cnt <= r_bit_cnt + 16'd1;
            end
            RX_DATA: begin
               if (r_bit_cnt == DIV_LAST) begin
                  r_bit_cnt <= '0;
                  r_shift   <= {r_rx_s2, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
                  else r_bit_idx <= r_bit_idx + 3'd1;
               end else r_bit_cnt <= r_bit_cnt + 16'd1;
            end
            default: begin
               if (r_bit_cnt == DIV_LAST) begin
                  r_bit_cnt  <= '0;
                  r_rx_state <= RX_IDLE;
                  if (r_rx_s2) begin
                     r_byte_vld <= 1'b1;
                     r_rx_byte  <= r_shift;
                  end else r_frame_err <= 1'b1;
               end else r_bit_cnt <= r_bit_cnt + 16'd1;
            end
         endcase
      end
   end

   assign w_timeout = (r_p_state != P_IDLE) && (r_p_state != P_FINISH) &&
                      !r_byte_vld && (r_to_cnt == TO_LAST);

   // Command parser; every command ending funnels through P_FINISH so done_o trails the last write.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_p_state <= P_IDLE;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_wr      <= 1'b0;
         r_hold    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_to_cnt  <= '0;
`ifdef LOADER_CKSUM_EN
         r_sum     <= '0;
`endif
      end else begin
         r_wr   <= 1'b0;
         r_done <= 1'b0;
         if (r_frame_err) r_err <= 1'b1;
         if (r_p_state == P_IDLE || r_byte_vld) r_to_cnt <= '0;
         else r_to_cnt <= r_to_cnt + 32'd1;
`ifdef LOADER_CKSUM_EN
         if (r_byte_vld) r_sum <= (r_p_state == P_IDLE) ? 8'd0 : r_sum + r_rx_byte;
`endif
         if (w_timeout) begin
            r_p_state <= P_IDLE;
            r_err     <= 1'b1;
            r_hold    <= 1'b0;
         end else begin
            case (r_p_state)
               P_IDLE: if (r_byte_vld && r_rx_byte == 8'h57) begin
                  r_p_state <= P_ADDR_H;
                  r_err     <= 1'b0;
                  r_hold    <= 1'b1;
               end
               P_ADDR_H: if (r_byte_vld) begin
                  r_addr[15:8] <= r_rx_byte;
                  r_p_state    <= P_ADDR_L;
               end
               P_ADDR_L: if (r_byte_vld) begin
                  r_addr[7:0] <= r_rx_byte;
                  r_p_state   <= P_CNT_H;
               end
               P_CNT_H: if (r_byte_vld) begin
                  r_cnt[15:8] <= r_rx_byte;
                  r_p_state   <= P_CNT_L;
               end
               P_CNT_L: if (r_byte_vld) begin
                  r_cnt[7:0] <= r_rx_byte;
                  r_p_state  <= ({r_cnt[15:8], r_rx_byte} == 16'd0) ? P_AFTER_LAST : P_DATA_H;
               end
               P_DATA_H: if (r_byte_vld) begin
                  r_hi      <= r_rx_byte;
                  r_p_state <= P_DATA_L;
               end
               P_DATA_L: if (r_byte_vld) begin
                  r_wr      <= 1'b1;
                  r_waddr   <= r_addr;
                  r_wdata   <= {r_hi, r_rx_byte};
                  r_addr    <= r_addr + 16'd1;
                  r_cnt     <= r_cnt - 16'd1;
                  r_p_state <= (r_cnt == 16'd1) ? P_AFTER_LAST : P_DATA_H;
               end
`ifdef LOADER_CKSUM_EN
               P_CKSUM: if (r_byte_vld) begin
                  if (r_rx_byte != r_sum) r_err <= 1'b1;
                  r_p_state <= P_FINISH;
               end
`endif
               default: begin
                  r_done    <= 1'b1;
                  r_hold    <= 1'b0;
                  r_p_state <= P_IDLE;
               end
            endcase
         end
      end
   end

endmodule
